// File: rtl/tow_pkg.sv
// Shared types and helpers for the tug-of-war match core.
package tow_pkg;

   typedef enum logic [2:0] {
      S_BOOT,
      S_DARK,
      S_PLAY,
      S_WIN,
      S_MATCH
   } tow_state_e;

   localparam logic SIDE_LEFT  = 1'b1;
   localparam logic SIDE_RIGHT = 1'b0;

   localparam int MAX_LED = 64;

   // Round-win display: the winner's half of the track lit, centre dark.
   function automatic logic [MAX_LED-1:0] win_pattern(input logic side, input int unsigned side_len);
      logic [MAX_LED-1:0] ones;
      ones = (MAX_LED'(1) << side_len) - MAX_LED'(1);
      return (side == SIDE_LEFT) ? (ones << (side_len + 1)) : ones;
   endfunction

endpackage

// File: rtl/tow_sync_edge.sv
// Two-flop synchroniser for one push button, with registered level and rise pulse
// that both become valid on the same cycle.
module tow_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic level,
   output logic rise
);

   logic meta_q,  meta_d;
   logic level_q, level_d;
   logic rise_q,  rise_d;

   always_comb begin
      meta_d  = async_in;
      level_d = meta_q;
      rise_d  = meta_q & ~level_q;
   end

   // NOTE: state flops use non-blocking assignments and an async active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q  <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         meta_q  <= meta_d;
         level_q <= level_d;
         rise_q  <= rise_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;

endmodule

// File: rtl/tow_match.sv
// Tug-of-war game core: synchronised buttons drive a position FSM with dark phases,
// per-side round scores and best-of-N match termination.
module tow_match
   import tow_pkg::*;
#(
   parameter  int SIDE_LEN      = 3,
   parameter  int DARK_CYCLES   = 4,
   parameter  int WIN_HOLD      = 16,
   parameter  int ROUNDS_TO_WIN = 1,
   localparam int SW            = $clog2(ROUNDS_TO_WIN + 1),
   localparam int LW            = 2 * SIDE_LEN + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pbl,
   input  logic          pbr,
   output logic [LW-1:0] led_out,
   output logic [SW-1:0] score_l,
   output logic [SW-1:0] score_r,
   output logic          match_over,
   output logic          winner
);

   localparam int TMAX = (DARK_CYCLES > WIN_HOLD) ? DARK_CYCLES : WIN_HOLD;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int PW   = $clog2(SIDE_LEN + 1) + 1;

   localparam logic signed [PW-1:0] POS_MAX = PW'(SIDE_LEN);
   localparam logic signed [PW-1:0] POS_MIN = -POS_MAX;

   logic pl_s, pl_rise, pr_s, pr_rise;

   tow_sync_edge u_sync_l (
      .clk      (clk),
      .rst_n    (rst),
      .async_in (pbl),
      .level    (pl_s),
      .rise     (pl_rise)
   );

   tow_sync_edge u_sync_r (
      .clk      (clk),
      .rst_n    (rst),
      .async_in (pbr),
      .level    (pr_s),
      .rise     (pr_rise)
   );

   tow_state_e            state_q,      state_d;
   logic signed [PW-1:0]  pos_q,        pos_d;
   logic [TW-1:0]         timer_q,      timer_d;
   logic [SW-1:0]         score_l_q,    score_l_d;
   logic [SW-1:0]         score_r_q,    score_r_d;
   logic                  armed_q,      armed_d;
   logic                  match_over_q, match_over_d;
   logic                  winner_q,     winner_d;
   logic                  win_side_q,   win_side_d;

   logic [SW-1:0] score_l_inc, score_r_inc;
   logic [PW-1:0] led_idx;

   assign score_l_inc = (score_l_q == SW'(ROUNDS_TO_WIN)) ? score_l_q : score_l_q + SW'(1);
   assign score_r_inc = (score_r_q == SW'(ROUNDS_TO_WIN)) ? score_r_q : score_r_q + SW'(1);
   assign led_idx     = PW'(SIDE_LEN) + pos_q;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d      = state_q;
      pos_d        = pos_q;
      timer_d      = timer_q;
      score_l_d    = score_l_q;
      score_r_d    = score_r_q;
      armed_d      = armed_q;
      match_over_d = match_over_q;
      winner_d     = winner_q;
      win_side_d   = win_side_q;

      if (!pl_s && !pr_s) begin
         armed_d = 1'b1;
      end else if (state_q != S_PLAY) begin
         armed_d = 1'b0;
      end

      case (state_q)
         S_BOOT: begin
            state_d = S_DARK;
            timer_d = TW'(DARK_CYCLES - 1);
         end
         S_DARK: begin
            if (timer_q == '0) state_d = S_PLAY;
            else               timer_d = timer_q - TW'(1);
         end
         S_PLAY: begin
            // Arming needs both levels low the cycle before, so an armed high level is always a rise.
            if (armed_q && (pl_rise || pr_rise)) begin
               armed_d = 1'b0;
               if (pl_rise && !pr_rise) begin
                  if (pos_q == POS_MAX) begin
                     state_d    = S_WIN;
                     timer_d    = TW'(WIN_HOLD - 1);
                     win_side_d = SIDE_LEFT;
                     score_l_d  = score_l_inc;
                     if (score_l_inc == SW'(ROUNDS_TO_WIN)) begin
                        match_over_d = 1'b1;
                        winner_d     = SIDE_LEFT;
                     end
                  end else begin
                     pos_d   = pos_q + PW'(1);
                     state_d = S_DARK;
                     timer_d = TW'(DARK_CYCLES - 1);
                  end
               end else if (pr_rise && !pl_rise) begin
                  if (pos_q == POS_MIN) begin
                     state_d    = S_WIN;
                     timer_d    = TW'(WIN_HOLD - 1);
                     win_side_d = SIDE_RIGHT;
                     score_r_d  = score_r_inc;
                     if (score_r_inc == SW'(ROUNDS_TO_WIN)) begin
                        match_over_d = 1'b1;
                        winner_d     = SIDE_RIGHT;
                     end
                  end else begin
                     pos_d   = pos_q - PW'(1);
                     state_d = S_DARK;
                     timer_d = TW'(DARK_CYCLES - 1);
                  end
               end
            end
         end
         S_WIN: begin
            if (match_over_q) begin
               state_d = S_MATCH;
            end else if (timer_q == '0) begin
               pos_d   = '0;
               state_d = S_DARK;
               timer_d = TW'(DARK_CYCLES - 1);
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_MATCH: begin
         end
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_BOOT;
         pos_q        <= '0;
         timer_q      <= '0;
         score_l_q    <= '0;
         score_r_q    <= '0;
         armed_q      <= 1'b0;
         match_over_q <= 1'b0;
         winner_q     <= SIDE_RIGHT;
         win_side_q   <= SIDE_RIGHT;
      end else begin
         state_q      <= state_d;
         pos_q        <= pos_d;
         timer_q      <= timer_d;
         score_l_q    <= score_l_d;
         score_r_q    <= score_r_d;
         armed_q      <= armed_d;
         match_over_q <= match_over_d;
         winner_q     <= winner_d;
         win_side_q   <= win_side_d;
      end
   end

   always_comb begin
      led_out = '0;
      case (state_q)
         S_BOOT:         led_out = '1;
         S_PLAY:         led_out = LW'(1) << led_idx;
         S_WIN, S_MATCH: led_out = LW'(win_pattern(win_side_q, SIDE_LEN));
         default:        led_out = '0;
      endcase
   end

   assign score_l    = score_l_q;
   assign score_r    = score_r_q;
   assign match_over = match_over_q;
   assign winner     = winner_q;

endmodule

// File: tb/tb_tow_match.sv
// Bench for tow_match: instance A uses defaults, instance B is best-of-two with short hold.
module tb_tow_match;

   localparam int S = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b0, pbl_a = 1'b0, pbr_a = 1'b0;
   logic rst_b = 1'b0, pbl_b = 1'b0, pbr_b = 1'b0;
   logic [6:0] led_a, led_b;
   logic [0:0] sl_a, sr_a;
   logic [1:0] sl_b, sr_b;
   logic mo_a, win_a, mo_b, win_b;

   tow_match dut_a (
      .clk(clk), .rst(rst_a), .pbl(pbl_a), .pbr(pbr_a), .led_out(led_a),
      .score_l(sl_a), .score_r(sr_a), .match_over(mo_a), .winner(win_a)
   );

   tow_match #(.SIDE_LEN(3), .DARK_CYCLES(4), .WIN_HOLD(8), .ROUNDS_TO_WIN(2)) dut_b (
      .clk(clk), .rst(rst_b), .pbl(pbl_b), .pbr(pbr_b), .led_out(led_b),
      .score_l(sl_b), .score_r(sr_b), .match_over(mo_b), .winner(win_b)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   localparam int P_BOOT = 0, P_DARK = 1, P_PLAY = 2, P_WIN = 3, P_MATCH = 4;
   int cfg_dark [2] = '{4, 4};
   int cfg_hold [2] = '{16, 8};
   int cfg_r    [2] = '{1, 2};

   int m_phase [2];
   int m_pos   [2];
   int m_rem   [2];
   int m_sl    [2];
   int m_sr    [2];
   bit m_armed [2];
   bit m_side  [2];
   bit m_mo    [2];
   bit m_win   [2];
   bit m_s1l [2], m_s1r [2], m_vl [2], m_vr [2];

   task automatic model_reset(input int i);
      m_phase[i] = P_BOOT; m_pos[i] = 0; m_rem[i] = 0;
      m_sl[i] = 0; m_sr[i] = 0; m_armed[i] = 0; m_side[i] = 0;
      m_mo[i] = 0; m_win[i] = 0;
      m_s1l[i] = 0; m_s1r[i] = 0; m_vl[i] = 0; m_vr[i] = 0;
   endtask

   task automatic round_won(input int i, input bit left);
      int sc;
      if (left) begin m_sl[i] = (m_sl[i] < cfg_r[i]) ? m_sl[i] + 1 : m_sl[i]; sc = m_sl[i]; end
      else      begin m_sr[i] = (m_sr[i] < cfg_r[i]) ? m_sr[i] + 1 : m_sr[i]; sc = m_sr[i]; end
      m_side[i] = left;
      if (sc == cfg_r[i]) begin
         m_mo[i] = 1; m_win[i] = left; m_phase[i] = P_MATCH;
      end else begin
         m_phase[i] = P_WIN; m_rem[i] = cfg_hold[i];
      end
   endtask

   task automatic start_dark(input int i);
      m_phase[i] = P_DARK; m_rem[i] = cfg_dark[i];
   endtask

   task automatic model_step(input int i, input bit bl, input bit br);
      bit vl, vr, na;
      vl = m_vl[i]; vr = m_vr[i]; na = m_armed[i];
      if (!vl && !vr) na = 1;
      else if (m_phase[i] != P_PLAY) na = 0;
      case (m_phase[i])
         P_BOOT: start_dark(i);
         P_DARK: begin m_rem[i]--; if (m_rem[i] == 0) m_phase[i] = P_PLAY; end
         P_PLAY: if (m_armed[i] && (vl || vr)) begin
            na = 0;
            if (vl && !vr) begin
               if (m_pos[i] == S) round_won(i, 1);
               else begin m_pos[i]++; start_dark(i); end
            end else if (vr && !vl) begin
               if (m_pos[i] == -S) round_won(i, 0);
               else begin m_pos[i]--; start_dark(i); end
            end
         end
         P_WIN: begin
            m_rem[i]--;
            if (m_rem[i] == 0) begin m_pos[i] = 0; start_dark(i); end
         end
         default: ;
      endcase
      m_armed[i] = na;
      m_vl[i] = m_s1l[i]; m_s1l[i] = bl;
      m_vr[i] = m_s1r[i]; m_s1r[i] = br;
   endtask

   function automatic int unsigned exp_led(input int i);
      case (m_phase[i])
         P_BOOT:         return (1 << (2 * S + 1)) - 1;
         P_PLAY:         return 1 << (S + m_pos[i]);
         P_WIN, P_MATCH: return m_side[i] ? (((1 << S) - 1) << (S + 1)) : ((1 << S) - 1);
         default:        return 0;
      endcase
   endfunction

   always @(posedge clk or negedge rst_a)
      if (!rst_a) model_reset(0); else model_step(0, pbl_a, pbr_a);
   always @(posedge clk or negedge rst_b)
      if (!rst_b) model_reset(1); else model_step(1, pbl_b, pbr_b);

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("a_led", 32'(led_a), exp_led(0));
      check("a_score_l", 32'(sl_a), m_sl[0]);
      check("a_score_r", 32'(sr_a), m_sr[0]);
      check("a_match_over", 32'(mo_a), 32'(m_mo[0]));
      if (m_mo[0]) check("a_winner", 32'(win_a), 32'(m_win[0]));
      check("b_led", 32'(led_b), exp_led(1));
      check("b_score_l", 32'(sl_b), m_sl[1]);
      check("b_score_r", 32'(sr_b), m_sr[1]);
      check("b_match_over", 32'(mo_b), 32'(m_mo[1]));
      if (m_mo[1]) check("b_winner", 32'(win_b), 32'(m_win[1]));
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_a(input bit l, input bit r);
      @(negedge clk); pbl_a = l; pbr_a = r;
      @(negedge clk); pbl_a = 1'b0; pbr_a = 1'b0;
   endtask

   task automatic press_b(input bit l, input bit r);
      @(negedge clk); pbl_b = l; pbr_b = r;
      @(negedge clk); pbl_b = 1'b0; pbr_b = 1'b0;
   endtask

   task automatic held_pair_a;
      @(negedge clk); pbl_a = 1'b1;
      @(negedge clk); pbr_a = 1'b1;
      tick(10);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      tick(3);
      check("a_reset_led", 32'(led_a), 32'h7f);
      #2 rst_a = 1'b1;
      tick(1); check("a_boot_dark_first", 32'(led_a), 32'h00);
      tick(3); check("a_boot_dark_last", 32'(led_a), 32'h00);
      tick(1); check("a_centre", 32'(led_a), 32'b0001000);
      check("a_scores_zero", 32'({sl_a, sr_a}), 0);

      press_a(1, 0);
      tick(2); check("a_dark_after_push", 32'(led_a), 32'h00);
      tick(4); check("a_l1", 32'(led_a), 32'b0010000);
      press_a(1, 0);
      tick(6); check("a_l2", 32'(led_a), 32'b0100000);

      held_pair_a;
      check("a_l3_held_pair", 32'(led_a), 32'b1000000);
      pbl_a = 1'b0; pbr_a = 1'b0;
      tick(4);
      held_pair_a;
      check("a_left_win_led", 32'(led_a), 32'b1110000);
      check("a_left_score", 32'(sl_a), 1);
      check("a_match_over", 32'(mo_a), 1);
      check("a_winner_left", 32'(win_a), 1);
      pbl_a = 1'b0; pbr_a = 1'b0;
      tick(3);
      press_a(0, 1); press_a(1, 0);
      tick(8); check("a_match_frozen", 32'(led_a), 32'b1110000);

      @(negedge clk); #2 rst_a = 1'b0;
      #1 check("a_async_reset_led", 32'(led_a), 32'h7f);
      check("a_async_reset_score", 32'(sl_a), 0);
      check("a_async_reset_mo", 32'(mo_a), 0);
      tick(2); #2 rst_a = 1'b1;
      tick(5); check("a_centre_again", 32'(led_a), 32'b0001000);

      press_a(1, 1);
      tick(2); check("a_tie_no_dark", 32'(led_a), 32'b0001000);
      tick(6); check("a_tie_stays", 32'(led_a), 32'b0001000);
      press_a(0, 1); tick(6); check("a_r1", 32'(led_a), 32'b0000100);
      press_a(0, 1); tick(6); check("a_r2", 32'(led_a), 32'b0000010);
      press_a(0, 1); tick(6); check("a_r3", 32'(led_a), 32'b0000001);
      press_a(0, 1); tick(2);
      check("a_right_win_led", 32'(led_a), 32'b0000111);
      check("a_right_score", 32'(sr_a), 1);
      check("a_right_mo", 32'(mo_a), 1);
      check("a_winner_right", 32'(win_a), 0);

      // Best-of-two instance.
      @(negedge clk); #2 rst_b = 1'b1;
      tick(5); check("b_centre", 32'(led_b), 32'b0001000);
      for (int n = 0; n < 3; n++) begin
         press_b(1, 0); tick(6);
      end
      check("b_l3", 32'(led_b), 32'b1000000);
      press_b(1, 0);
      tick(2); check("b_round1_led", 32'(led_b), 32'b1110000);
      check("b_round1_score", 32'(sl_b), 1);
      check("b_round1_not_over", 32'(mo_b), 0);
      tick(7); check("b_hold_last", 32'(led_b), 32'b1110000);
      tick(1); check("b_restart_dark", 32'(led_b), 32'h00);
      tick(4); check("b_round2_centre", 32'(led_b), 32'b0001000);
      check("b_round2_score", 32'(sl_b), 1);
      for (int n = 0; n < 3; n++) begin
         press_b(1, 0); tick(6);
      end
      press_b(1, 0); tick(2);
      check("b_match_led", 32'(led_b), 32'b1110000);
      check("b_match_score", 32'(sl_b), 2);
      check("b_match_over", 32'(mo_b), 1);
      check("b_match_winner", 32'(win_b), 1);

      @(negedge clk); #2 rst_b = 1'b0;
      tick(2); #2 rst_b = 1'b1;
      tick(5);
      for (int n = 0; n < 4; n++) begin
         press_b(1, 0); tick(6);
      end
      tick(8); check("b_run2_round2_centre", 32'(led_b), 32'b0001000);
      press_b(1, 0); tick(3);
      #2 rst_b = 1'b0;
      #1 check("b_mid_reset_led", 32'(led_b), 32'h7f);
      check("b_mid_reset_score", 32'(sl_b), 0);
      check("b_mid_reset_mo", 32'(mo_b), 0);

      tick(2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tow_match.md
Name: tow_match

Overview:
- Parametrised successor of the tug-of-war game core (`tow`).
- Two players push buttons: the first press in each exchange moves the lit LED one step toward the presser.
- Pushing past the last LED wins the round.
- New over `tow`: configurable track length, configurable dark-phase length, input synchronisers, tie handling, per-side score counters, best-of-N match mode with automatic round restart.

Parameters:
- SIDE_LEN, 3, LEDs per side excluding centre; led_out width = 2*SIDE_LEN+1 (min 1).
- DARK_CYCLES, 4, cycles led_out is dark between moves (min 1).
- WIN_HOLD, 16, cycles the round-win pattern is shown before the next round starts (min 1).
- ROUNDS_TO_WIN, 1, round wins needed to win the match; 1 = legacy behaviour (win latched until reset).
- SW = $clog2(ROUNDS_TO_WIN+1), derived width of the score outputs.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- pbl  in  1  left push button, asynchronous, active-high
- pbr  in  1  right push button, asynchronous, active-high
- led_out  out  2*SIDE_LEN+1  track display; MSB = far left
- score_l  out  SW  left rounds won
- score_r  out  SW  right rounds won
- match_over  out  1  high once either score reaches ROUNDS_TO_WIN
- winner  out  1  1 = left, 0 = right; valid only while match_over = 1

Behaviour:
- Reset (rst = 0, async):
  - state = S_BOOT, led_out = all ones.
  - pos = 0, scores = 0, match_over = 0, winner = 0, armed = 0, timer = 0, synchronisers cleared.
  - Reset asserted mid-round or mid-match aborts everything immediately.
- Position pos: signed, range -SIDE_LEN..+SIDE_LEN, positive = left.
  - In S_PLAY, led_out is one-hot with bit (SIDE_LEN+pos) set; centre (pos = 0) = bit SIDE_LEN.
- Inputs: each button passes through a 2-FF synchroniser plus a rise detector.
  - Button sampled high at edge k is visible to the FSM as pl_s/pr_s after edge k+1.
  - The FSM acts on it at edge k+2.
- Arming:
  - armed is set on any edge where pl_s = 0 and pr_s = 0.
  - armed is cleared on any accepted push, on a tie, and whenever a button is held outside S_PLAY.
- FSM:
  - S_BOOT: first edge after reset release -> S_DARK, timer = DARK_CYCLES-1, led_out = 0.
  - S_DARK:
    - led_out = 0; timer decrements each cycle.
    - At timer = 0 -> S_PLAY. Total dark time is exactly DARK_CYCLES cycles.
  - S_PLAY with armed = 1:
    - pl_s only: if pos = +SIDE_LEN -> S_WIN, left round win; else pos += 1 and -> S_DARK.
    - pr_s only: mirror of the above (pos -= 1, or right round win at pos = -SIDE_LEN).
    - pl_s and pr_s on the same cycle: tie; no move, armed = 0, stay in S_PLAY.
  - S_PLAY with armed = 0: presses ignored. A button held from the previous exchange never moves the LED. A later press by the opponent while the first is still held is ignored.
  - S_WIN:
    - On entry: the winner's score increments and timer = WIN_HOLD-1.
    - led_out shows the win pattern: left = top SIDE_LEN bits set, right = bottom SIDE_LEN bits set, centre bit 0.
    - If the new score = ROUNDS_TO_WIN: match_over = 1, winner set, -> S_MATCH (same pattern, held until reset).
    - Otherwise, at timer = 0: pos = 0 -> S_DARK -> S_PLAY (new round).
  - S_MATCH: terminal state; all presses ignored.
- Latency: pbl high sampled at edge k in S_PLAY (armed) -> led_out = 0 after edge k+2 -> new position after edge k+2+DARK_CYCLES.
- Scores saturate at ROUNDS_TO_WIN. Scores never wrap.

Decomposition:
- Shared package tow_pkg holds:
  - state enum (S_BOOT, S_DARK, S_PLAY, S_WIN, S_MATCH)
  - side constants SIDE_LEFT = 1, SIDE_RIGHT = 0
  - win-pattern helper function
- Sub-module tow_sync_edge (2-FF synchroniser, registered level output plus rise pulse): one instance per button.
- The core FSM, position register, timer and score counters form the top module.

Test Plan (defaults unless noted):
- Reset pulse then release -> led_out = 1111111 during reset, 0000000 for 4 cycles, then 0001000; scores 0.
- pbl one-cycle pulse twice (released between presses) -> 0010000, then 0100000; each move preceded by exactly 4 dark cycles.
- At L2, pbl pressed, pbr pressed 1 cycle later, both held -> L3 (1000000) only. Repeat at L3 -> 1110000, score_l = 1, match_over = 1, winner = 1. Further presses ignored.
- From N0, pbl and pbr rise on the same edge -> led stays 0001000, no dark phase. Release both, then pbr alone -> 0000100.
- Right-only pushes from N0 (4 presses) -> R1, R2, R3 (0000001), then 0000111, score_r = 1.
- ROUNDS_TO_WIN = 2, WIN_HOLD = 8: left wins round 1 -> win pattern for 8 cycles, 4 dark cycles, then 0001000, score_l = 1, match_over = 0. Left wins round 2 -> match_over = 1, winner = 1. Assert rst mid-round 2 in a separate run -> immediate 1111111, scores 0.
